// File: rtl/regfile_vec_masked.sv
// -----------------------------------------------------------------------------
// regfile_vec_masked
//
// Purpose:
//   Vector register file for the vector datapath. NUM_REGS registers of
//   LANES x LANE_W bits each. Registers live at BASE_ADDR..BASE_ADDR+NUM_REGS-1
//   of the unified ADDR_W-bit register namespace.
//   - Two combinational read ports, one synchronous write port with a per-lane
//     write mask.
//   - A sequential clear engine zeroes one register per cycle, both after
//     reset and whenever clr is requested.
//
// Optional feature (macro VRF_BYPASS_EN):
//   Defined   : a read port addressing the register being written in the same
//               cycle returns the merged write data (masked lanes from vwd3,
//               unmasked lanes from the current register).
//   Undefined : read ports return the pre-write contents; the new data is
//               visible the cycle after the clock edge.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous, active-low reset
//   clr      in   1        request full-file clear (sampled at clk edge)
//   vwe3     in   1        write enable
//   vmask3   in   LANES    per-lane write mask, 1 = lane written
//   vwa3     in   ADDR_W   write address
//   vwd3     in   VEC_W    write data
//   vra1     in   ADDR_W   read address, port 1
//   vra2     in   ADDR_W   read address, port 2
//   vrd1     out  VEC_W    read data, port 1
//   vrd2     out  VEC_W    read data, port 2
//   busy     out  1        clear engine active (also high while in reset)
//   wr_drop  out  1        one-cycle pulse: the write at the previous edge
//                          was discarded
//
// Handshake / write semantics:
//   A write is offered whenever vwe3=1 at a clock edge. It is accepted only
//   when the engine is IDLE, clr=0 and vwa3 is in range; otherwise it is
//   dropped without touching any register and wr_drop pulses on the next
//   cycle. vmask3=0 with vwe3=1 is an accepted write that changes nothing.
//   Priority: reset > clr > write.
//
// The FSM state is held in the signal 'state' (type state_t) so checkers can
// bind to it directly.
// -----------------------------------------------------------------------------
module regfile_vec_masked #(
    parameter int                NUM_REGS  = 16,
    parameter int                LANES     = 32,
    parameter int                LANE_W    = 8,
    parameter int                ADDR_W    = 5,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 5'h10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     vwe3,
    input  logic [LANES-1:0]         vmask3,
    input  logic [ADDR_W-1:0]        vwa3,
    input  logic [LANES*LANE_W-1:0]  vwd3,
    input  logic [ADDR_W-1:0]        vra1,
    input  logic [ADDR_W-1:0]        vra2,
    output logic [LANES*LANE_W-1:0]  vrd1,
    output logic [LANES*LANE_W-1:0]  vrd2,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Address helpers. Arithmetic is done one bit wider than the address so an
    // address below BASE_ADDR becomes a large offset instead of wrapping into
    // the valid window.
    // -------------------------------------------------------------------------
    function automatic logic [ADDR_W:0] addr_off(input logic [ADDR_W-1:0] a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) &&
               (addr_off(a) < (ADDR_W+1)'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(addr_off(a));
    endfunction

    // Lane-wise merge: lanes with mask=1 take new data, others keep old data.
    function automatic logic [VEC_W-1:0] lane_merge(
        input logic [VEC_W-1:0] old_v,
        input logic [VEC_W-1:0] new_v,
        input logic [LANES-1:0] mask
    );
        logic [VEC_W-1:0] res;
        res = old_v;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                res[i*LANE_W +: LANE_W] = new_v[i*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Storage and control state
    // -------------------------------------------------------------------------
    logic [VEC_W-1:0] regs [NUM_REGS];

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;

    logic             wa_ok;
    logic [IDX_W-1:0] wa_idx;
    logic             wr_accept;
    logic             wr_drop_nx;
    logic [VEC_W-1:0] wr_merged;

    logic             ra1_ok;
    logic [IDX_W-1:0] ra1_idx;
    logic             ra2_ok;
    logic [IDX_W-1:0] ra2_idx;

    // -------------------------------------------------------------------------
    // Write decode
    // -------------------------------------------------------------------------
    always_comb begin
        wa_ok      = addr_ok(vwa3);
        wa_idx     = addr_idx(vwa3);
        // rst gates acceptance so nothing is written while reset is held.
        wr_accept  = rst && vwe3 && (state == ST_IDLE) && !clr && wa_ok;
        wr_drop_nx = vwe3 && ((state == ST_CLEAR) || clr || !wa_ok);
        wr_merged  = lane_merge(regs[wa_idx], vwd3, vmask3);
    end

    // -------------------------------------------------------------------------
    // Clear-engine FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_CLEAR: begin
                if (idx == LAST_IDX) begin
                    state_nx = ST_IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            ST_IDLE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_CLEAR;
                idx_nx   = '0;
            end
        endcase
        // clr restarts the sweep from register 0 in either state.
        if (clr) begin
            state_nx = ST_CLEAR;
            idx_nx   = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Clear-engine FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            idx     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            wr_drop <= wr_drop_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Register array. The clear sweep and an accepted write are mutually
    // exclusive because writes are only accepted in IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs[0] <= '0;
        end else if (state == ST_CLEAR) begin
            regs[idx] <= '0;
        end else if (wr_accept) begin
            regs[wa_idx] <= wr_merged;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. busy also covers the reset window so reads are masked before
    // the first reset edge has loaded the state register.
    // -------------------------------------------------------------------------
    assign busy = !rst || (state == ST_CLEAR);

    always_comb begin
        ra1_ok  = addr_ok(vra1);
        ra1_idx = addr_idx(vra1);
        vrd1    = ra1_ok ? regs[ra1_idx] : '0;
`ifdef VRF_BYPASS_EN
        if (wr_accept && (vra1 == vwa3)) begin
            vrd1 = wr_merged;
        end
`endif
        if (busy) begin
            vrd1 = '0;
        end
    end

    always_comb begin
        ra2_ok  = addr_ok(vra2);
        ra2_idx = addr_idx(vra2);
        vrd2    = ra2_ok ? regs[ra2_idx] : '0;
`ifdef VRF_BYPASS_EN
        if (wr_accept && (vra2 == vwa3)) begin
            vrd2 = wr_merged;
        end
`endif
        if (busy) begin
            vrd2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_vec_masked.sv
// Directed bench for regfile_vec_masked at default parameters.
module tb_regfile_vec_masked;

    localparam int LANES  = 32;
    localparam int LANE_W = 8;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              vwe3;
    logic [LANES-1:0]  vmask3;
    logic [ADDR_W-1:0] vwa3;
    logic [VEC_W-1:0]  vwd3;
    logic [ADDR_W-1:0] vra1;
    logic [ADDR_W-1:0] vra2;
    logic [VEC_W-1:0]  vrd1;
    logic [VEC_W-1:0]  vrd2;
    logic              busy;
    logic              wr_drop;

    int passed = 0;
    int total  = 0;

    logic [VEC_W-1:0] v_aa;
    logic [VEC_W-1:0] v_55;
    logic [VEC_W-1:0] v_aa55;
    logic [VEC_W-1:0] v_cc;
    logic [VEC_W-1:0] v_77;
    logic [VEC_W-1:0] v_ff;
    logic [VEC_W-1:0] exp_byp;
    int               n;

    regfile_vec_masked dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .vwe3    (vwe3),
        .vmask3  (vmask3),
        .vwa3    (vwa3),
        .vwd3    (vwd3),
        .vra1    (vra1),
        .vra2    (vra2),
        .vrd1    (vrd1),
        .vrd2    (vrd2),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit later so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VEC_W-1:0] obs,
                         input logic [VEC_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts cycles (samples) with busy=1, bounded so a stuck engine ends.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        v_aa   = {32{8'hAA}};
        v_55   = {32{8'h55}};
        v_aa55 = {{31{8'hAA}}, 8'h55};
        v_cc   = {32{8'hCC}};
        v_77   = {32{8'h77}};
        v_ff   = {32{8'hFF}};

        rst = 1'b0; clr = 1'b0; vwe3 = 1'b0; vmask3 = '0;
        vwa3 = '0; vwd3 = '0; vra1 = 5'h10; vra2 = 5'h1F;

        // Reset held for two edges
        tick();
        tick();
        check("reset_busy",    VEC_W'(busy), VEC_W'(1));
        check("reset_vrd1",    vrd1, '0);
        check("reset_vrd2",    vrd2, '0);
        check("reset_wr_drop", VEC_W'(wr_drop), '0);

        // Release: busy must stay high for exactly 16 cycles
        rst = 1'b1;
        #1;
        check("clear_vrd1_busy", vrd1, '0);
        count_busy(n);
        check("reset_busy_cycles", VEC_W'(n), VEC_W'(16));
        check("idle_wr_drop", VEC_W'(wr_drop), '0);

        // Full write to 0x10
        vwe3 = 1'b1; vwa3 = 5'h10; vmask3 = '1; vwd3 = v_aa;
        tick();
        vwe3 = 1'b0; vra1 = 5'h10; vra2 = 5'h11;
        #1;
        check("full_write_vrd1", vrd1, v_aa);
        check("full_write_vrd2", vrd2, '0);
        check("full_write_no_drop", VEC_W'(wr_drop), '0);

        // Masked write: only lane 0 takes new data
        vwe3 = 1'b1; vwa3 = 5'h10; vmask3 = 32'h0000_0001; vwd3 = v_55;
        tick();
        vwe3 = 1'b0; vra2 = 5'h10;
        #1;
        check("masked_vrd1", vrd1, v_aa55);
        check("masked_vrd2_same", vrd2, v_aa55);

        // Out-of-range read below BASE_ADDR
        vra2 = 5'h00;
        #1;
        check("oor_read_0x00", vrd2, '0);

        // Dropped write: address out of range
        vwe3 = 1'b1; vwa3 = 5'h05; vmask3 = '1; vwd3 = v_ff;
        tick();
        vwe3 = 1'b0;
        #1;
        check("oor_wr_drop", VEC_W'(wr_drop), VEC_W'(1));
        check("oor_no_change", vrd1, v_aa55);
        tick();
        check("wr_drop_pulse_end", VEC_W'(wr_drop), '0);

        // Mask=0 write is a legal no-op
        vwe3 = 1'b1; vwa3 = 5'h10; vmask3 = '0; vwd3 = v_ff;
        tick();
        vwe3 = 1'b0;
        #1;
        check("mask0_no_drop", VEC_W'(wr_drop), '0);
        check("mask0_no_change", vrd1, v_aa55);

        // Same-cycle read of the register being written
        vwe3 = 1'b1; vwa3 = 5'h11; vmask3 = '1; vwd3 = v_cc; vra1 = 5'h11;
        #1;
`ifdef VRF_BYPASS_EN
        exp_byp = v_cc;
`else
        exp_byp = '0;
`endif
        check("bypass_same_cycle", vrd1, exp_byp);
        tick();
        vwe3 = 1'b0;
        #1;
        check("bypass_next_cycle", vrd1, v_cc);

        // Write top register, then clr with a simultaneous write
        vwe3 = 1'b1; vwa3 = 5'h1F; vmask3 = '1; vwd3 = v_77;
        tick();
        vwe3 = 1'b0; vra1 = 5'h1F;
        #1;
        check("top_reg_write", vrd1, v_77);

        clr = 1'b1; vwe3 = 1'b1; vwa3 = 5'h12; vwd3 = v_ff;
        tick();
        clr = 1'b0; vwe3 = 1'b0;
        #1;
        check("clr_wr_drop", VEC_W'(wr_drop), VEC_W'(1));
        check("clr_busy", VEC_W'(busy), VEC_W'(1));
        count_busy(n);
        check("clr_busy_cycles", VEC_W'(n), VEC_W'(16));
        vra1 = 5'h10; vra2 = 5'h11;
        #1;
        check("clr_reg10_zero", vrd1, '0);
        check("clr_reg11_zero", vrd2, '0);
        vra1 = 5'h1F; vra2 = 5'h12;
        #1;
        check("clr_reg1f_zero", vrd1, '0);
        check("clr_reg12_zero", vrd2, '0);

        // Restart the clear sweep mid-way
        vwe3 = 1'b1; vwa3 = 5'h1F; vmask3 = '1; vwd3 = v_77;
        tick();
        vwe3 = 1'b0;
        #1;
        check("rewrite_1f", vrd1, v_77);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        // Clear cycle 0: a write while busy is dropped
        vwe3 = 1'b1; vwa3 = 5'h13; vwd3 = v_ff;
        tick();
        vwe3 = 1'b0;
        #1;
        check("busy_wr_drop", VEC_W'(wr_drop), VEC_W'(1));
        for (int i = 0; i < 7; i++) tick();
        // Now at clear cycle 8
        check("busy_at_cycle8", VEC_W'(busy), VEC_W'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        count_busy(n);
        check("restart_busy_cycles", VEC_W'(n), VEC_W'(16));
        vra1 = 5'h1F; vra2 = 5'h13;
        #1;
        check("restart_reg1f_zero", vrd1, '0);
        check("busy_write_lost", vrd2, '0);

        // final report
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
